child_event_collector: RTL

Collects single-word events from up to 15 child instances beneath one hierarchy node and forwards them upward as one ordered stream tagged with the source child index. The parent node instantiates it once, between its child instances and the next level up. It uses round-robin arbitration into a small FIFO, with a valid/ready handshake on both sides and a 16-bit event counter for debug.

---
 rtl/child_event_collector.sv | 61 ++++++
 1 files changed

// File: rtl/child_event_collector.sv
// child_event_collector: round-robin merge of child events into a tagged FIFO stream
module child_event_collector #(
  parameter int NUM_CHILD = 15,
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CHILD-1:0]          child_valid,
  input  logic [NUM_CHILD*DATA_W-1:0]   child_data,
  output logic [NUM_CHILD-1:0]          child_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [3:0]                    out_id,
  output logic [DATA_W-1:0]             out_data,
  output logic [15:0]                   event_count
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W+3:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic [3:0] ptr, grant;
  logic [4:0] sum, idx;
  logic found, full, empty, push, pop;
  assign full = (wptr - rptr) == (AW+1)'(DEPTH);
  assign empty = wptr == rptr;
  always_comb begin
    found = 1'b0;
    grant = '0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < NUM_CHILD; k++) begin
      sum = {1'b0, ptr} + 5'(k);
      idx = (sum >= 5'(NUM_CHILD)) ? sum - 5'(NUM_CHILD) : sum;
      if (!found && child_valid[idx[3:0]]) begin
        found = 1'b1;
        grant = idx[3:0];
      end
    end
  end
  assign child_ready = (!rst && !full && found) ? NUM_CHILD'(1) << grant : '0;
  assign push = |child_ready;
  assign out_valid = !empty && !rst;
  assign pop = out_valid && out_ready;
  assign {out_id, out_data} = out_valid ? mem[rptr[AW-1:0]] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      ptr <= '0;
      event_count <= '0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= {grant, child_data[grant*DATA_W +: DATA_W]};
        wptr <= wptr + 1'b1;
        ptr <= (grant == 4'(NUM_CHILD-1)) ? 4'd0 : grant + 4'd1;
        event_count <= event_count + 16'd1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end
endmodule
